amp_expand: RTL and testbench
=============================

AMP_EXPAND -- requirements
Module: amp_expand

Interface
REQ-001 Parameter: HOLD_LEN, default 8, number of accepted samples the held gain persists after the window peak falls.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset; synchronous, active-high.
REQ-004 Port: in_valid  input  1  inchan/in_thresh valid this cycle; a sample is accepted on every cycle in_valid=1, with no backpressure.
REQ-005 Port: inchan  input  16  two's-complement audio sample.
REQ-006 Port: in_thresh  input  4  threshold; effective threshold T = {1'b0, in_thresh, 11'b0}.
REQ-007 Port: out_valid  output  1  outchan valid; single-cycle pulse per accepted sample.
REQ-008 Port: outchan  output  16  expanded two's-complement sample.
REQ-009 Port: active  output  1  high while the state is EXPAND or HOLD.

Function
REQ-010 Window and magnitude: maintain the absolute values of the last 4 accepted samples, current sample included; |x| of 0x8000 SHALL clamp to 0x7FFF.
REQ-011 Peak and raw gain: peak P is the window maximum; D = P - T in 16-bit arithmetic; k_raw = 0 if D[15]=1, else k_raw = D[14:11].
REQ-012 Gain state machine: the states are FILL, IDLE, EXPAND and HOLD, and exactly one transition is evaluated per accepted sample. k_eff below means the value after that sample's update.
- FILL: k_eff = 0 for the first 3 accepted samples after reset. On the 4th accepted sample, go to EXPAND if k_raw>0, else IDLE; apply k_eff = k_raw to that same sample.
- IDLE: if k_raw>0, go to EXPAND and set k_eff = k_raw; otherwise k_eff = 0.
- EXPAND: if k_raw >= k_eff, set k_eff = k_raw. If k_raw < k_eff, go to HOLD, keep k_eff, and set hold count = 1.
- HOLD: if k_raw >= k_eff, go to EXPAND and set k_eff = k_raw. Otherwise, when hold count = HOLD_LEN, set k_eff = k_raw and go to EXPAND if k_raw>0, else IDLE. Otherwise increment hold count and keep k_eff.
REQ-013 Output arithmetic: M = |x| + ((|x| * k_eff) >> 4), using a 20-bit product and a 17-bit sum. M saturates to 0x7FFF. outchan = -M if inchan[15]=1, else M.
REQ-014 Latency: the sample accepted at cycle t appears with out_valid=1 at cycle t+2. Back-to-back accepts produce back-to-back outputs in order.
REQ-015 Pipeline stages: stage 1 registers |x|, sign and k_eff. Stage 2 registers outchan and out_valid.
REQ-016 Window, state, hold count and k_eff SHALL change only on accepted samples; in_valid=0 cycles are invisible to the state machine.
REQ-017 in_thresh SHALL be sampled per accepted sample; a change takes effect on the next accept.
REQ-018 outchan SHALL hold its last value while out_valid=0.
REQ-019 inchan=0 SHALL always give outchan=0.

Reset
REQ-020 While rst=1 at a clock edge, the following SHALL be cleared at that edge: out_valid=0, outchan=0, active=0, window=0, k_eff=0, hold count=0, state=FILL.
REQ-021 Reset mid-stream SHALL discard samples in flight; no out_valid may appear for samples accepted before the reset edge.
REQ-022 A sample presented in the same cycle as rst=1 SHALL NOT be accepted.

Structure
REQ-023 Package amp_pkg SHALL hold: SAMPLE_W=16, THR_W=4, WIN_LEN=4, the default HOLD_LEN, and the state enum {FILL, IDLE, EXPAND, HOLD}.
REQ-024 One sub-module, amp_window4, SHALL own the 4-entry magnitude shift window and the peak comparator tree. Its inputs are clk, rst, shift enable and the new magnitude; its output is the peak of the window including the incoming magnitude.
REQ-025 Shared arithmetic (the 16-bit adder and the 16x4 multiplier) SHALL be reused from the existing library blocks.

Verification
REQ-026 Fill and expand: in_thresh=4, four accepts of 0x4000 -> outputs 0x4000, 0x4000, 0x4000, 0x5000 (k=4), each 2 cycles after its accept; active rises after the 4th.
REQ-027 Sign: same setup with 0xC000 samples -> outputs 0xC000 ×3, then 0xB000.
REQ-028 Saturation: in_thresh=0, four accepts of 0x7000 -> 4th output 0x7FFF (k=14).
REQ-029 Hold/release: after REQ-026, accept 0x0100 continuously.
- Outputs 1-3 are 0x0140 with k=4 from the window.
- Outputs 4-11 are 0x0140 in HOLD (8 samples).
- Output 12 is 0x0100, state IDLE, active=0.
REQ-030 Gaps and reset: insert random in_valid=0 gaps into REQ-026 -> identical output sequence. Assert rst between the 2nd and 3rd accepts -> no out_valid for pre-reset samples, and the state machine restarts in FILL.

Source files
------------

// File: rtl/amp_pkg.sv
// Shared types, constants and arithmetic helpers for the amp_expand
// downward expander.
package amp_pkg;

    localparam int SAMPLE_W     = 16;
    localparam int THR_W        = 4;
    localparam int WIN_LEN      = 4;
    localparam int HOLD_LEN_DEF = 8;
    localparam int K_W          = 4;
    localparam int PROD_W       = SAMPLE_W + K_W;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        IDLE   = 2'd1,
        EXPAND = 2'd2,
        HOLD   = 2'd3
    } amp_state_e;

    // Magnitude of a two's-complement sample; the most negative code clamps
    // so the result always fits in 15 bits.
    function automatic logic [SAMPLE_W-1:0] abs_clamp(input logic [SAMPLE_W-1:0] x);
        if (x == 16'h8000) begin
            return 16'h7FFF;
        end else if (x[SAMPLE_W-1]) begin
            return 16'h0000 - x;
        end else begin
            return x;
        end
    endfunction

    function automatic logic [SAMPLE_W-1:0] add16(input logic [SAMPLE_W-1:0] a,
                                                  input logic [SAMPLE_W-1:0] b,
                                                  input logic                cin);
        return SAMPLE_W'(a + b + SAMPLE_W'(cin));
    endfunction

    function automatic logic [PROD_W-1:0] mul16x4(input logic [SAMPLE_W-1:0] a,
                                                  input logic [K_W-1:0]      b);
        return PROD_W'(a) * PROD_W'(b);
    endfunction

endpackage

// File: rtl/amp_window4.sv
// Sliding magnitude window: the three previous accepted magnitudes are stored
// and the incoming one is the fourth entry, so the peak reflects the current sample.
module amp_window4
    import amp_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                shift_en_i,
    input  logic [SAMPLE_W-1:0] mag_i,
    output logic [SAMPLE_W-1:0] peak_o
);

    logic [SAMPLE_W-1:0] hist_q [WIN_LEN-1];
    logic [SAMPLE_W-1:0] max_a;
    logic [SAMPLE_W-1:0] max_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WIN_LEN-1; i++) begin
                hist_q[i] <= '0;
            end
        end else if (shift_en_i) begin
            hist_q[0] <= mag_i;
            for (int i = 1; i < WIN_LEN-1; i++) begin
                hist_q[i] <= hist_q[i-1];
            end
        end
    end

    always_comb begin
        max_a  = (mag_i > hist_q[0]) ? mag_i : hist_q[0];
        max_b  = (hist_q[1] > hist_q[2]) ? hist_q[1] : hist_q[2];
        peak_o = (max_a > max_b) ? max_a : max_b;
    end

endmodule

// File: rtl/amp_expand.sv
// Peak-driven downward expander: a windowed peak above threshold sets a gain
// boost k_eff, held for HOLD_LEN accepts after the peak falls; two-stage output pipe.
module amp_expand
    import amp_pkg::*;
#(
    parameter int HOLD_LEN = HOLD_LEN_DEF
)
(
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [SAMPLE_W-1:0] inchan,
    input  logic [THR_W-1:0]    in_thresh,
    output logic                out_valid,
    output logic [SAMPLE_W-1:0] outchan,
    output logic                active,
    output amp_state_e          dbg_state
);

    localparam int HOLD_W = $clog2(HOLD_LEN + 1);
    localparam int FILL_W = $clog2(WIN_LEN);

    // Input handshake: a sample is taken on every clock with in_valid=1 and
    // rst=0; there is no ready. out_valid pulses once per taken sample,
    // two clocks later, and outchan holds its value in between.
    logic                accept;
    logic [SAMPLE_W-1:0] mag;
    logic [SAMPLE_W-1:0] peak;
    logic [SAMPLE_W-1:0] thr;
    logic [SAMPLE_W-1:0] diff;
    logic [K_W-1:0]      k_raw;

    amp_state_e          state_q, state_d;
    logic [K_W-1:0]      k_q, k_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [FILL_W-1:0]   fill_q, fill_d;

    logic                s1_valid_q;
    logic [SAMPLE_W-1:0] s1_mag_q;
    logic                s1_sign_q;
    logic [K_W-1:0]      s1_k_q;

    logic [PROD_W-1:0]   prod;
    logic [SAMPLE_W:0]   sum17;
    logic [SAMPLE_W-1:0] m_sat;
    logic [SAMPLE_W-1:0] out_d;
    logic                out_valid_q;
    logic [SAMPLE_W-1:0] outchan_q;

    assign accept = in_valid && !rst;
    assign mag    = abs_clamp(inchan);
    assign thr    = {1'b0, in_thresh, 11'b0};

    amp_window4 u_window (
        .clk        (clk),
        .rst        (rst),
        .shift_en_i (accept),
        .mag_i      (mag),
        .peak_o     (peak)
    );

    // D = P - T; a negative difference means no boost.
    assign diff  = add16(peak, ~thr, 1'b1);
    assign k_raw = diff[SAMPLE_W-1] ? '0 : K_W'(diff >> 11);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
            k_q     <= '0;
            hold_q  <= '0;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            hold_q  <= hold_d;
            fill_q  <= fill_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        hold_d  = hold_q;
        fill_d  = fill_q;
        if (accept) begin
            case (state_q)
                FILL: begin
                    if (fill_q == FILL_W'(WIN_LEN - 1)) begin
                        k_d     = k_raw;
                        state_d = (k_raw != '0) ? EXPAND : IDLE;
                    end else begin
                        fill_d = fill_q + 1'b1;
                        k_d    = '0;
                    end
                end
                IDLE: begin
                    if (k_raw != '0) begin
                        state_d = EXPAND;
                        k_d     = k_raw;
                    end else begin
                        k_d = '0;
                    end
                end
                EXPAND: begin
                    if (k_raw >= k_q) begin
                        k_d = k_raw;
                    end else begin
                        state_d = HOLD;
                        hold_d  = HOLD_W'(1);
                    end
                end
                HOLD: begin
                    if (k_raw >= k_q) begin
                        state_d = EXPAND;
                        k_d     = k_raw;
                        hold_d  = '0;
                    end else if (hold_q == HOLD_W'(HOLD_LEN)) begin
                        k_d     = k_raw;
                        state_d = (k_raw != '0) ? EXPAND : IDLE;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                default: begin
                    state_d = FILL;
                end
            endcase
        end
    end

    always_comb begin
        active    = (state_q == EXPAND) || (state_q == HOLD);
        dbg_state = state_q;
    end

    // Stage 1 carries the gain chosen for this very sample, not the old one.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_mag_q   <= '0;
            s1_sign_q  <= 1'b0;
            s1_k_q     <= '0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_mag_q  <= mag;
                s1_sign_q <= inchan[SAMPLE_W-1];
                s1_k_q    <= k_d;
            end
        end
    end

    always_comb begin
        prod  = mul16x4(s1_mag_q, s1_k_q);
        sum17 = {1'b0, s1_mag_q} + {1'b0, SAMPLE_W'(prod >> 4)};
        m_sat = (sum17 > 17'h07FFF) ? 16'h7FFF : sum17[SAMPLE_W-1:0];
        out_d = s1_sign_q ? (16'h0000 - m_sat) : m_sat;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            outchan_q   <= '0;
        end else begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                outchan_q <= out_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign outchan   = outchan_q;

endmodule

// File: tb/tb_amp_expand.sv
// Directed bench for amp_expand: fill/expand, sign, saturation, hold/release,
// gaps, mid-stream reset and threshold/zero boundaries against hand-computed vectors.
module tb_amp_expand;
    import amp_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] inchan = '0;
    logic [3:0]  in_thresh = '0;
    logic        out_valid;
    logic [15:0] outchan;
    logic        active;
    amp_state_e  dbg_state;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [15:0] got_q[$];
    int          got_cyc_q[$];
    int          acc_cyc_q[$];
    logic [15:0] exp_q[$];

    amp_expand #(.HOLD_LEN(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .inchan    (inchan),
        .in_thresh (in_thresh),
        .out_valid (out_valid),
        .outchan   (outchan),
        .active    (active),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            got_q.push_back(outchan);
            got_cyc_q.push_back(cyc);
        end
    end

    // One clock: drive inputs, let the rising edge take them, resume just
    // after the following falling edge (monitor has already run).
    task automatic step(input logic r, input logic v, input logic [15:0] x);
        rst      = r;
        in_valid = v;
        inchan   = x;
        if (v && !r) acc_cyc_q.push_back(cyc);
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'($urandom));
    endtask

    task automatic clear_q();
        got_q.delete();
        got_cyc_q.delete();
        acc_cyc_q.delete();
        exp_q.delete();
    endtask

    task automatic reset_dut();
        step(1'b1, 1'b0, 16'h0);
        step(1'b1, 1'b0, 16'h0);
        step(1'b0, 1'b0, 16'h0);
        clear_q();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        total++; if (outchan !== 16'h0) begin bad++; $display("FAIL reset_outchan: got %h expected 0000", outchan); end
        total++; if (active !== 1'b0) begin bad++; $display("FAIL reset_active: got %b expected 0", active); end
        total++; if (dbg_state !== FILL) begin bad++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, FILL); end
        reset_dut();
    endtask

    task automatic test_fill_expand();
        in_thresh = 4'd4;
        exp_q = '{16'h4000, 16'h4000, 16'h4000, 16'h5000};
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'h4000);
        total++; if (active !== 1'b0) begin bad++; $display("FAIL fill_active_pre: got %b expected 0", active); end
        step(1'b0, 1'b1, 16'h4000);
        total++; if (active !== 1'b1) begin bad++; $display("FAIL fill_active_post: got %b expected 1", active); end
        total++; if (dbg_state !== EXPAND) begin bad++; $display("FAIL fill_state: got %0d expected %0d", dbg_state, EXPAND); end
        idle(4);
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL fill_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL fill_out[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
            total++; if (got_cyc_q[i] - acc_cyc_q[i] != 2) begin bad++; $display("FAIL fill_latency[%0d]: got %0d expected 2", i, got_cyc_q[i] - acc_cyc_q[i]); end
        end
        total++; if (out_valid !== 1'b0 || outchan !== 16'h5000) begin bad++; $display("FAIL fill_hold_value: got %b/%h expected 0/5000", out_valid, outchan); end
        clear_q();
    endtask

    // Continues from test_fill_expand without a reset.
    task automatic test_hold_release();
        amp_state_e exp_st;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b1, 16'h0100);
            exp_st = (i < 3) ? EXPAND : (i < 11) ? HOLD : IDLE;
            exp_q.push_back((i < 11) ? 16'h0140 : 16'h0100);
            total++; if (dbg_state !== exp_st) begin bad++; $display("FAIL hold_state[%0d]: got %0d expected %0d", i, dbg_state, exp_st); end
            total++; if (active !== (exp_st != IDLE)) begin bad++; $display("FAIL hold_active[%0d]: got %b expected %b", i, active, exp_st != IDLE); end
        end
        idle(4);
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL hold_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL hold_out[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
        clear_q();
    endtask

    task automatic test_sign();
        reset_dut();
        in_thresh = 4'd4;
        exp_q = '{16'hC000, 16'hC000, 16'hC000, 16'hB000};
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 16'hC000);
        idle(4);
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL sign_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL sign_out[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
        clear_q();
    endtask

    task automatic test_saturation();
        reset_dut();
        in_thresh = 4'd0;
        exp_q = '{16'h7000, 16'h7000, 16'h7000, 16'h7FFF};
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 16'h7000);
        idle(4);
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL sat_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL sat_out[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
        clear_q();
    endtask

    task automatic test_gaps();
        reset_dut();
        in_thresh = 4'd4;
        exp_q = '{16'h4000, 16'h4000, 16'h4000, 16'h5000};
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 16'h4000);
            idle($urandom_range(1, 3));
        end
        idle(4);
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL gap_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL gap_out[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
            total++; if (got_cyc_q[i] - acc_cyc_q[i] != 2) begin bad++; $display("FAIL gap_latency[%0d]: got %0d expected 2", i, got_cyc_q[i] - acc_cyc_q[i]); end
        end
        clear_q();
    endtask

    task automatic test_reset_midstream();
        reset_dut();
        in_thresh = 4'd4;
        step(1'b0, 1'b1, 16'h4000);
        step(1'b0, 1'b1, 16'h4000);
        clear_q();
        step(1'b1, 1'b1, 16'h4000);
        idle(4);
        total++; if (got_q.size() != 0) begin bad++; $display("FAIL rst_mid_flush: got %0d outputs expected 0", got_q.size()); end
        total++; if (dbg_state !== FILL) begin bad++; $display("FAIL rst_mid_state: got %0d expected %0d", dbg_state, FILL); end
        total++; if (active !== 1'b0) begin bad++; $display("FAIL rst_mid_active: got %b expected 0", active); end
        clear_q();
        exp_q = '{16'h4000, 16'h4000, 16'h4000, 16'h5000};
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 16'h4000);
        idle(4);
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL rst_mid_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rst_mid_out[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
        clear_q();
    endtask

    // Threshold change on the 4th accept (T=0x1000 -> k=6), then a zero
    // sample, then 0x8000 whose magnitude clamps and saturates (k=13).
    task automatic test_thresh_zero();
        reset_dut();
        in_thresh = 4'd4;
        exp_q = '{16'h4000, 16'h4000, 16'h4000, 16'h5800, 16'h0000, 16'h8001};
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'h4000);
        in_thresh = 4'd2;
        step(1'b0, 1'b1, 16'h4000);
        step(1'b0, 1'b1, 16'h0000);
        step(1'b0, 1'b1, 16'h8000);
        idle(4);
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL thr_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL thr_out[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
        clear_q();
    endtask

    initial begin
        test_reset();
        test_fill_expand();
        test_hold_release();
        test_sign();
        test_saturation();
        test_gaps();
        test_reset_midstream();
        test_thresh_zero();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
